// File: rtl/uriscv_mem_arb.sv
// Arbitrates the core's fetch and data ports onto one shared memory port.
// One transaction is outstanding at a time, and each one is bounded by a timeout.
module uriscv_mem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RESET_PRIO_D   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic [31:0] mem_i_inst_o,
    output logic        mem_i_error_o,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_error_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWaitI = 2'd1;
    localparam logic [1:0] StWaitD = 2'd2;

    localparam logic [15:0] CntLast    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        LastDReset = (RESET_PRIO_D == 0);

    logic [1:0]  state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] cnt_q, cnt_d;

    logic        req_i, req_d, grant_i, grant_d;
    logic        resp, resp_err;
    logic [31:0] resp_data;

    assign req_i = mem_i_rd_i;
    assign req_d = mem_d_rd_i | (|mem_d_wr_i);
    // last_d_q set means data was served last, so fetch wins the next tie
    assign grant_i = req_i & (~req_d | last_d_q);
    assign grant_d = req_d & ~grant_i;

    always_comb begin
        state_d         = state_q;
        last_d_d        = last_d_q;
        cnt_d           = cnt_q;
        resp            = 1'b0;
        resp_err        = 1'b0;
        resp_data       = 32'd0;
        mem_i_accept_o  = 1'b0;
        mem_i_valid_o   = 1'b0;
        mem_i_inst_o    = 32'd0;
        mem_i_error_o   = 1'b0;
        mem_d_accept_o  = 1'b0;
        mem_d_ack_o     = 1'b0;
        mem_d_data_rd_o = 32'd0;
        mem_d_error_o   = 1'b0;
        mem_addr_o      = 32'd0;
        mem_data_wr_o   = 32'd0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = 4'd0;

        case (state_q)
            StIdle: begin
                if (grant_i) begin
                    mem_addr_o     = mem_i_pc_i;
                    mem_rd_o       = 1'b1;
                    mem_i_accept_o = mem_accept_i;
                    if (mem_accept_i) begin
                        state_d  = StWaitI;
                        last_d_d = 1'b0;
                        cnt_d    = 16'd0;
                    end
                end else if (grant_d) begin
                    mem_addr_o     = mem_d_addr_i;
                    mem_data_wr_o  = mem_d_data_wr_i;
                    mem_rd_o       = mem_d_rd_i;
                    mem_wr_o       = mem_d_wr_i;
                    mem_d_accept_o = mem_accept_i;
                    if (mem_accept_i) begin
                        state_d  = StWaitD;
                        last_d_d = 1'b1;
                        cnt_d    = 16'd0;
                    end
                end
            end
            StWaitI, StWaitD: begin
                // A real ack beats a timeout landing in the same cycle
                if (mem_ack_i) begin
                    resp      = 1'b1;
                    resp_data = mem_data_rd_i;
                    state_d   = StIdle;
                end else if (cnt_q == CntLast) begin
                    resp     = 1'b1;
                    resp_err = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (state_q == StWaitD) begin
                    mem_d_ack_o     = resp;
                    mem_d_data_rd_o = resp_data;
                    mem_d_error_o   = resp_err;
                end else begin
                    mem_i_valid_o = resp;
                    mem_i_inst_o  = resp_data;
                    mem_i_error_o = resp_err;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs stay quiet while reset is held, whatever the inputs do
        if (!rst_i) begin
            mem_i_accept_o  = 1'b0;
            mem_i_valid_o   = 1'b0;
            mem_i_inst_o    = 32'd0;
            mem_i_error_o   = 1'b0;
            mem_d_accept_o  = 1'b0;
            mem_d_ack_o     = 1'b0;
            mem_d_data_rd_o = 32'd0;
            mem_d_error_o   = 1'b0;
            mem_addr_o      = 32'd0;
            mem_data_wr_o   = 32'd0;
            mem_rd_o        = 1'b0;
            mem_wr_o        = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            last_d_q <= LastDReset;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uriscv_mem_arb.sv
// Self-checking bench for uriscv_mem_arb: a scoreboard of expected responses is
// filled at each accept and drained by a monitor that watches the response pulses.
module tb_uriscv_mem_arb;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_i_rd_i = 1'b0;
    logic [31:0] mem_i_pc_i = '0;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [31:0] mem_i_inst_o;
    logic        mem_d_rd_i = 1'b0;
    logic [3:0]  mem_d_wr_i = '0;
    logic [31:0] mem_d_addr_i = '0;
    logic [31:0] mem_d_data_wr_i = '0;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [31:0] mem_d_data_rd_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic        mem_accept_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_rd_i = '0;

    wire [138:0] all_out = {mem_i_accept_o, mem_i_valid_o, mem_i_inst_o, mem_i_error_o,
                            mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
                            mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o};
    wire [5:0] pulses = {mem_i_accept_o, mem_i_valid_o, mem_i_error_o,
                         mem_d_accept_o, mem_d_ack_o, mem_d_error_o};

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    uriscv_mem_arb #(
        .TIMEOUT_CYCLES(TO),
        .RESET_PRIO_D  (0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mem_i_rd_i     (mem_i_rd_i),
        .mem_i_pc_i     (mem_i_pc_i),
        .mem_i_accept_o (mem_i_accept_o),
        .mem_i_valid_o  (mem_i_valid_o),
        .mem_i_inst_o   (mem_i_inst_o),
        .mem_i_error_o  (mem_i_error_o),
        .mem_d_rd_i     (mem_d_rd_i),
        .mem_d_wr_i     (mem_d_wr_i),
        .mem_d_addr_i   (mem_d_addr_i),
        .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_accept_o (mem_d_accept_o),
        .mem_d_ack_o    (mem_d_ack_o),
        .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_error_o  (mem_d_error_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_wr_o  (mem_data_wr_o),
        .mem_rd_o       (mem_rd_o),
        .mem_wr_o       (mem_wr_o),
        .mem_accept_i   (mem_accept_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_rd_i  (mem_data_rd_i)
    );

    // Response monitor: every valid/ack pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t        e;
        logic [69:0] got, want;
        if (mem_i_valid_o || mem_d_ack_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp t=%0t i_valid=%b d_ack=%b", $time,
                         mem_i_valid_o, mem_d_ack_o);
            end else begin
                e    = exp_q.pop_front();
                got  = {mem_i_valid_o, mem_d_ack_o, mem_i_error_o, mem_d_error_o,
                        mem_i_inst_o, mem_d_data_rd_o};
                want = {~e.is_d, e.is_d, e.err & ~e.is_d, e.err & e.is_d,
                        e.is_d ? 32'd0 : e.data, e.is_d ? e.data : 32'd0};
                if (got !== want) begin
                    errors++;
                    $display("FAIL resp t=%0t got=%h expected=%h", $time, got, want);
                end
            end
        end
        vectors++;
        if ((!mem_i_valid_o && mem_i_inst_o !== 32'd0) ||
            (!mem_d_ack_o && mem_d_data_rd_o !== 32'd0)) begin
            errors++;
            $display("FAIL data_nonzero_idle t=%0t inst=%h drd=%h", $time, mem_i_inst_o,
                     mem_d_data_rd_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        mem_i_rd_i      = 1'b0;
        mem_i_pc_i      = '0;
        mem_d_rd_i      = 1'b0;
        mem_d_wr_i      = '0;
        mem_d_addr_i    = '0;
        mem_d_data_wr_i = '0;
        mem_accept_i    = 1'b0;
        mem_ack_i       = 1'b0;
        mem_data_rd_i   = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i         = 1'b0;
        mem_i_rd_i    = 1'b1;
        mem_d_rd_i    = 1'b1;
        mem_d_wr_i    = 4'hf;
        mem_accept_i  = 1'b1;
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h5555_aaaa;
        #2;
        vectors++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0", all_out);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs_clocked got=%h expected=0", all_out);
        end
        clr_inputs();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_fetch();
        tick();
        mem_i_rd_i   = 1'b1;
        mem_i_pc_i   = 32'h8000_0000;
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_i_accept_o, mem_d_accept_o, mem_rd_o, mem_wr_o, mem_addr_o} !==
            {1'b1, 1'b0, 1'b1, 4'b0000, 32'h8000_0000}) begin
            errors++;
            $display("FAIL fetch_grant got=%b/%b/%b/%h/%h expected=1/0/1/0/80000000",
                     mem_i_accept_o, mem_d_accept_o, mem_rd_o, mem_wr_o, mem_addr_o);
        end
        exp_q.push_back({1'b0, 32'h0000_0513, 1'b0});
        tick();
        mem_i_rd_i    = 1'b0;
        mem_accept_i  = 1'b0;
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h0000_0513;
        tick();
        // Back in IDLE with ack still high: a stray ack must not pulse anything
        @(negedge clk);
        vectors++;
        if (pulses !== 6'd0) begin
            errors++;
            $display("FAIL stray_ack got=%b expected=000000", pulses);
        end
        clr_inputs();
    endtask

    task automatic test_contention();
        logic [31:0] dat;
        logic        exp_d;
        do_reset();
        tick();
        mem_i_rd_i   = 1'b1;
        mem_i_pc_i   = 32'h0000_0100;
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = 32'h0000_2000;
        mem_accept_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2) == 1;
            dat   = 32'ha000_0000 + k;
            @(negedge clk);
            vectors++;
            if ({mem_i_accept_o, mem_d_accept_o, mem_rd_o, mem_wr_o, mem_addr_o} !==
                {~exp_d, exp_d, 1'b1, 4'b0000, exp_d ? 32'h0000_2000 : 32'h0000_0100}) begin
                errors++;
                $display("FAIL contention_grant k=%0d got=%b/%b/%h expected_d=%b", k,
                         mem_i_accept_o, mem_d_accept_o, mem_addr_o, exp_d);
            end
            exp_q.push_back({exp_d, dat, 1'b0});
            tick();
            mem_ack_i     = 1'b1;
            mem_data_rd_i = dat;
            @(negedge clk);
            vectors++;
            if ({mem_i_accept_o, mem_d_accept_o, mem_rd_o, mem_wr_o} !== 7'd0) begin
                errors++;
                $display("FAIL wait_quiet k=%0d got=%b expected=0", k,
                         {mem_i_accept_o, mem_d_accept_o, mem_rd_o, mem_wr_o});
            end
            tick();
            mem_ack_i     = 1'b0;
            mem_data_rd_i = '0;
        end
        clr_inputs();
    endtask

    task automatic test_stall();
        tick();
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = 32'h0000_4000;
        mem_accept_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_d_accept_o, mem_i_accept_o, mem_rd_o, mem_addr_o} !==
            {1'b0, 1'b0, 1'b1, 32'h0000_4000}) begin
            errors++;
            $display("FAIL stall_no_accept got=%b/%b/%h expected=0/1/00004000",
                     mem_d_accept_o, mem_rd_o, mem_addr_o);
        end
        tick();
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_d_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_then_accept got=%b expected=1", mem_d_accept_o);
        end
        exp_q.push_back({1'b1, 32'h0bad_f00d, 1'b0});
        tick();
        clr_inputs();
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h0bad_f00d;
        tick();
        clr_inputs();
    endtask

    task automatic test_write();
        tick();
        mem_d_wr_i      = 4'b0011;
        mem_d_addr_i    = 32'h8000_1000;
        mem_d_data_wr_i = 32'hdead_beef;
        mem_accept_i    = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_d_accept_o, mem_i_accept_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_data_wr_o} !==
            {1'b1, 1'b0, 1'b0, 4'b0011, 32'h8000_1000, 32'hdead_beef}) begin
            errors++;
            $display("FAIL write_drive got=%b/%b/%h/%h/%h expected=1/0/3/80001000/deadbeef",
                     mem_d_accept_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_data_wr_o);
        end
        exp_q.push_back({1'b1, 32'h1234_5678, 1'b0});
        tick();
        clr_inputs();
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h1234_5678;
        tick();
        clr_inputs();
    endtask

    task automatic test_timeout();
        tick();
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = 32'h0000_3000;
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_d_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_accept got=%b expected=1", mem_d_accept_o);
        end
        exp_q.push_back({1'b1, 32'd0, 1'b1});
        tick();
        clr_inputs();
        mem_data_rd_i = 32'hffff_ffff;
        for (int w = 1; w < TO; w++) begin
            @(negedge clk);
            vectors++;
            if ({mem_d_ack_o, mem_d_error_o} !== 2'b00) begin
                errors++;
                $display("FAIL timeout_early w=%0d got=%b expected=00", w,
                         {mem_d_ack_o, mem_d_error_o});
            end
            tick();
        end
        // Timeout pulse lands in this cycle and the monitor checks it
        @(negedge clk);
        tick();
        mem_ack_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (pulses !== 6'd0) begin
            errors++;
            $display("FAIL late_ack_ignored got=%b expected=000000", pulses);
        end
        tick();
        clr_inputs();

        // Ack in the same cycle as the timeout is a normal response
        mem_i_rd_i   = 1'b1;
        mem_i_pc_i   = 32'h0000_0040;
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_i_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL race_accept got=%b expected=1", mem_i_accept_o);
        end
        exp_q.push_back({1'b0, 32'h0000_cafe, 1'b0});
        tick();
        clr_inputs();
        for (int w = 1; w < TO; w++) begin
            @(negedge clk);
            vectors++;
            if (mem_i_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL race_early w=%0d got=%b expected=0", w, mem_i_valid_o);
            end
            tick();
        end
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h0000_cafe;
        tick();
        clr_inputs();
    endtask

    task automatic test_reset_in_wait();
        tick();
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = 32'h0000_5000;
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_d_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_accept got=%b expected=1", mem_d_accept_o);
        end
        tick();
        clr_inputs();
        #2;
        rst_i         = 1'b0;
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h7777_7777;
        #1;
        vectors++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs got=%h expected=0", all_out);
        end
        tick();
        tick();
        clr_inputs();
        rst_i = 1'b1;
        tick();
        mem_i_rd_i   = 1'b1;
        mem_i_pc_i   = 32'h8000_0004;
        mem_accept_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_i_accept_o, mem_addr_o} !== {1'b1, 32'h8000_0004}) begin
            errors++;
            $display("FAIL rstwait_fetch_grant got=%b/%h expected=1/80000004",
                     mem_i_accept_o, mem_addr_o);
        end
        exp_q.push_back({1'b0, 32'h0010_0073, 1'b0});
        tick();
        clr_inputs();
        mem_ack_i     = 1'b1;
        mem_data_rd_i = 32'h0010_0073;
        tick();
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_stall();
        test_write();
        test_timeout();
        test_reset_in_wait();
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uriscv_mem_arb.md
URISCV_MEM_ARB -- requirements
Module: uriscv_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of WAIT-state cycles without mem_ack_i before the block aborts the transaction (range 1..65535).
REQ-002 SHALL have parameter RESET_PRIO_D, default 0, meaning the requester favoured at the first contention after reset (0 = instruction, 1 = data).
REQ-003 SHALL have the following ports, one per line as name, direction, width, meaning (clock and reset first):
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_i_rd_i  in  1  core fetch request.
- mem_i_pc_i  in  32  fetch address.
- mem_i_accept_o  out  1  fetch request accepted this cycle.
- mem_i_valid_o  out  1  fetch response valid (1-cycle pulse).
- mem_i_inst_o  out  32  fetched instruction.
- mem_i_error_o  out  1  fetch timed out (pulse, with valid).
- mem_d_rd_i  in  1  data read request.
- mem_d_wr_i  in  4  data byte write strobes.
- mem_d_addr_i  in  32  data address.
- mem_d_data_wr_i  in  32  write data.
- mem_d_accept_o  out  1  data request accepted this cycle.
- mem_d_ack_o  out  1  data response (1-cycle pulse; also for writes).
- mem_d_data_rd_o  out  32  read data.
- mem_d_error_o  out  1  data access timed out (pulse, with ack).
- mem_addr_o  out  32  shared-port address.
- mem_data_wr_o  out  32  shared-port write data.
- mem_rd_o  out  1  shared-port read request.
- mem_wr_o  out  4  shared-port byte strobes.
- mem_accept_i  in  1  shared port accepted the request.
- mem_ack_i  in  1  shared-port response.
- mem_data_rd_i  in  32  shared-port read data.

Function
REQ-004 SHALL use a 3-state FSM: IDLE, WAIT_I, WAIT_D; at most one transaction outstanding.
REQ-005 In IDLE, a data request SHALL be pending when mem_d_rd_i | (|mem_d_wr_i), and a fetch request SHALL be pending when mem_i_rd_i.
REQ-006 In IDLE with a single requester pending, that requester SHALL be granted combinationally.
REQ-007 In IDLE with both requesters pending, the grant SHALL go to the requester not served last (round-robin via a last_d register).
REQ-008 The granted request SHALL be driven on mem_addr_o/mem_data_wr_o/mem_rd_o/mem_wr_o in the same cycle; a fetch SHALL drive mem_rd_o=1 and mem_wr_o=0.
REQ-009 The granted requester's accept output SHALL equal mem_accept_i; the other accept output SHALL be 0.
REQ-010 On (grant & mem_accept_i), the FSM SHALL move to WAIT_I or WAIT_D, last_d SHALL update, and the timeout counter SHALL clear.
REQ-011 In WAIT_x, mem_rd_o and mem_wr_o SHALL be 0, and both accept outputs SHALL be 0.
REQ-012 In WAIT_x with mem_ack_i=1, the block SHALL pulse the owner's valid/ack combinationally in that cycle, route mem_data_rd_i to the owner's data output, and return to IDLE.
REQ-013 A new grant SHALL occur only from IDLE; the minimum per-transaction turnaround SHALL be accept cycle + ack cycle.
REQ-014 In WAIT_x without an ack, the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1, the block SHALL pulse the owner's valid/ack together with its error output, with data 0, and return to IDLE.
REQ-015 An ack arriving in the same cycle as the timeout SHALL win: the response is normal and no error is raised.
REQ-016 A mem_ack_i in IDLE (stray or late) SHALL be ignored; no outputs SHALL pulse.
REQ-017 The data outputs (mem_i_inst_o, mem_d_data_rd_o) SHALL be 0 when the corresponding valid/ack is 0.

Reset
REQ-018 On rst_i=0, the block SHALL asynchronously enter IDLE, clear the counter, and set last_d to ~RESET_PRIO_D.
REQ-019 During reset, all outputs SHALL be 0.
REQ-020 A reset asserted in WAIT_x SHALL abandon the transaction without issuing a response.
REQ-021 After reset deasserts, the first grant SHALL follow REQ-006/REQ-007.

Verification
REQ-022 Fetch only: pc=0x80000000 with accept and ack after 1 cycle -> i_accept=1, then i_valid=1 with inst=mem_data_rd_i, and d_ack stays 0.
REQ-023 Simultaneous fetch and data read after reset (RESET_PRIO_D=0) -> fetch granted first and then the data read; repeated contention alternates I, D, I, D.
REQ-024 Data write with strobes 4'b0011 at addr 0x80001000 -> mem_wr_o=4'b0011 and mem_rd_o=0; the ack yields d_ack=1 and i_valid=0.
REQ-025 No ack with TIMEOUT_CYCLES=4 -> d_ack=1 and d_error=1 in the 4th WAIT cycle with data 0; an ack one cycle later is ignored.
REQ-026 Reset asserted in WAIT_D -> all outputs 0 immediately; after release, a fresh fetch completes normally.
